// File: rtl/param_sync_fifo_if.sv
// param_sync_fifo_if: handshake/status bundle for param_sync_fifo.
//   D/Wr/Rd      producer/consumer requests (driven by master)
//   Q/QValid     registered read data and its one-cycle valid
//   Full/Empty   occupancy status, Err sticky misuse flag
//   Level        occupancy 0..DEPTH, only when FIFO_LEVEL_EN is defined
// Modports: slave = FIFO side, master = user side.
interface param_sync_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] D;
  logic             Wr;
  logic             Rd;
  logic [WIDTH-1:0] Q;
  logic             QValid;
  logic             Full;
  logic             Empty;
  logic             Err;
`ifdef FIFO_LEVEL_EN
  logic [AW:0]      Level;

  modport slave  (input D, Wr, Rd, output Q, QValid, Full, Empty, Err, Level);
  modport master (output D, Wr, Rd, input Q, QValid, Full, Empty, Err, Level);
`else
  modport slave  (input D, Wr, Rd, output Q, QValid, Full, Empty, Err);
  modport master (output D, Wr, Rd, input Q, QValid, Full, Empty, Err);
`endif
endinterface

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO of DEPTH x WIDTH words.
//   Clk   rising-edge clock
//   Rst   synchronous active-high reset (wins over Wr/Rd)
//   bus   param_sync_fifo_if.slave: D/Wr/Rd in, Q/QValid/Full/Empty/Err
//         out, plus Level when FIFO_LEVEL_EN is defined.
// Optional feature macro: FIFO_LEVEL_EN (exposes occupancy on bus.Level).
// Pointers carry one extra MSB so full and empty are distinguishable
// when the index bits match.
module param_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                Clk,
  input  logic                Rst,
  param_sync_fifo_if.slave    bus
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp, rp;
  logic [WIDTH-1:0] q_r;
  logic             qv_r, err_r;
  logic             full, empty, wr_ok, rd_ok;

  assign empty = (wp == rp);
  assign full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);

  // Acceptance uses the pre-edge flags only: no write-through on full,
  // no bypass on empty.
  assign wr_ok = bus.Wr && !full;
  assign rd_ok = bus.Rd && !empty;

  // Storage is never cleared; reset only blocks the write.
  always_ff @(posedge Clk) begin
    if (!Rst && wr_ok) mem[wp[AW-1:0]] <= bus.D;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wp    <= '0;
      rp    <= '0;
      q_r   <= '0;
      qv_r  <= 1'b0;
      err_r <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + PTR_ONE;
      if (rd_ok) begin
        rp  <= rp + PTR_ONE;
        q_r <= mem[rp[AW-1:0]];
      end
      qv_r <= rd_ok;
      if ((bus.Wr && full) || (bus.Rd && empty)) err_r <= 1'b1;
    end
  end

  assign bus.Q      = q_r;
  assign bus.QValid = qv_r;
  assign bus.Full   = full;
  assign bus.Empty  = empty;
  assign bus.Err    = err_r;
`ifdef FIFO_LEVEL_EN
  // Modulo 2*DEPTH difference of the registered pointers.
  assign bus.Level  = wp - rp;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench: DEPTH=4/WIDTH=8 instance driven by directed and random traffic
// against a queue model; a #(4,2) instance checks the positional override.
module tb_param_sync_fifo;
  localparam int W  = 8;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst, rst2;
  always #5 clk = ~clk;

  param_sync_fifo_if #(W, DP) bus ();
  param_sync_fifo_if #(4, 2)  bus2 ();

  param_sync_fifo #(W, DP) dut  (.Clk(clk), .Rst(rst),  .bus(bus));
  param_sync_fifo #(4, 2)  dut2 (.Clk(clk), .Rst(rst2), .bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored words.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_q;
  logic         m_qv, m_err;

  task automatic step(input logic r, input logic wr, input logic rd, input logic [W-1:0] d);
    bit was_full, was_empty;
    @(negedge clk);
    rst = r; bus.Wr = wr; bus.Rd = rd; bus.D = d;
    @(posedge clk);
    if (r) begin
      mq.delete(); m_q = '0; m_qv = 1'b0; m_err = 1'b0;
    end else begin
      was_full  = (mq.size() == DP);
      was_empty = (mq.size() == 0);
      m_qv = 1'b0;
      if (rd) begin
        if (was_empty) m_err = 1'b1;
        else begin m_q = mq.pop_front(); m_qv = 1'b1; end
      end
      if (wr) begin
        if (was_full) m_err = 1'b1;
        else mq.push_back(d);
      end
    end
    #1;
    chk("q",      bus.Q,      m_q);
    chk("qvalid", bus.QValid, m_qv);
    chk("full",   bus.Full,   mq.size() == DP);
    chk("empty",  bus.Empty,  mq.size() == 0);
    chk("err",    bus.Err,    m_err);
`ifdef FIFO_LEVEL_EN
    chk("level",  bus.Level,  mq.size());
`endif
  endtask

  task automatic step2(input logic r, input logic wr, input logic rd, input logic [3:0] d);
    @(negedge clk);
    rst2 = r; bus2.Wr = wr; bus2.Rd = rd; bus2.D = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; bus.Wr = 0; bus.Rd = 0; bus.D = '0;
    rst2 = 1'b1; bus2.Wr = 0; bus2.Rd = 0; bus2.D = '0;

    // Reset state, then basic ordered write/read.
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h11);
    step(0, 1, 0, 8'h22);
    step(0, 1, 0, 8'h33);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Fill, overflow with 0xAA, drain.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'hA0 + 8'(i));
    step(0, 1, 0, 8'hAA);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);

    // Read+write on empty: no bypass, error, word stored.
    step(1, 0, 0, 8'h00);
    step(0, 1, 1, 8'h5C);
    step(0, 0, 1, 8'h00);
    chk("bypass_rd", bus.Q, 8'h5C);

    // Wrap-around at half occupancy.
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h01);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 8'(i + 2));

    // Reset mid-burst with a read pending.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h40 + 8'(i));
    step(1, 0, 1, 8'h00);
    step(0, 1, 0, 8'h77);
    step(0, 1, 0, 8'h78);
    step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);

    // Random traffic, phases biased toward filling and draining.
    for (int ph = 0; ph < 6; ph++) begin
      int wpct = (ph % 2 == 0) ? 75 : 30;
      for (int i = 0; i < 80; i++)
        step($urandom_range(99) < 2, $urandom_range(99) < wpct,
             $urandom_range(99) < (100 - wpct), 8'($urandom));
    end

    // Override instance: WIDTH=4, DEPTH=2.
    step2(1, 0, 0, 4'h0);
    chk("o_empty0", bus2.Empty, 1'b1);
    step2(0, 1, 0, 4'hF);
    chk("o_full1", bus2.Full, 1'b0);
    step2(0, 1, 0, 4'h3);
    chk("o_full2", bus2.Full, 1'b1);
    step2(0, 1, 0, 4'h9);
    chk("o_err", bus2.Err, 1'b1);
    step2(0, 0, 1, 4'h0);
    chk("o_q0", bus2.Q, 4'hF);
    chk("o_qv0", bus2.QValid, 1'b1);
    step2(0, 0, 1, 4'h0);
    chk("o_q1", bus2.Q, 4'h3);
    chk("o_empty", bus2.Empty, 1'b1);
    step2(0, 0, 0, 4'h0);
    chk("o_qv_off", bus2.QValid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parameterized synchronous FIFO that buffers WIDTH-bit data words upstream of the team's parameterized data-path stages (D/Q style consumers). It decouples a bursty producer from a consumer that pulls one word per cycle. It also reports full/empty status, a sticky overflow/underflow error, and optionally the occupancy level. Width and depth are set per instance through parameters: positional override `#(WIDTH, DEPTH)` or `defparam`.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of storage entries; power of two, ≥2
- AW, $clog2(DEPTH), pointer width; derived, never overridden

- Clk  input  1  rising-edge clock, single clock domain
- Rst  input  1  synchronous, active-high reset
- D  input  WIDTH  write data
- Wr  input  1  write request
- Rd  input  1  read request
- Q  output  WIDTH  read data, registered
- QValid  output  1  high for exactly one cycle when Q carries a newly read word
- Full  output  1  DEPTH words stored
- Empty  output  1  zero words stored
- Err  output  1  sticky: set on write-while-full or read-while-empty
- Level  output  AW+1  occupancy 0..DEPTH (only with FIFO_LEVEL_EN)

## Operation
- Storage: DEPTH×WIDTH register array. Write pointer `wp` and read pointer `rp` are each AW+1 bits, with the extra MSB used for wrap detection.
- Empty = (wp == rp). Full = (wp[AW-1:0] == rp[AW-1:0]) and (wp[AW] != rp[AW]).
- Write accepted when Wr && !Full: mem[wp[AW-1:0]] <= D, then wp increments, wrapping modulo 2·DEPTH.
- Read accepted when Rd && !Empty: Q <= mem[rp[AW-1:0]], QValid <= 1, then rp increments.
- A cycle with no accepted read forces QValid to 0. Q holds its last value.
- Wr while Full: the word is dropped, wp is unchanged, and Err is set. This holds even if Rd is accepted in the same cycle; there is no write-through on full.
- Rd while Empty: there is no read, QValid = 0, and Err is set. This holds even if Wr is accepted in the same cycle; there is no bypass.
- Simultaneous accepted Wr and Rd when neither Full nor Empty: both pointers advance and the occupancy is unchanged.
- Err is cleared only by Rst.
- Status flags are derived combinationally from the registered pointers, so they change only at clock edges.
- Occupancy = wp − rp, computed modulo 2·DEPTH.

## Timing
- Reset, sampled on a rising Clk edge with Rst = 1:
  - wp = rp = 0
  - Q = 0, QValid = 0, Err = 0
  - Empty = 1, Full = 0, Level = 0
  - Memory contents are not cleared.
- Rst has priority over Wr/Rd in the same cycle. Any in-flight read is discarded, so QValid = 0 the cycle after reset.
- Read latency: Rd accepted at edge N produces Q/QValid valid after edge N, usable in cycle N+1.
- Write-to-read latency: a word written at edge N makes Empty drop after edge N. The earliest read is accepted at edge N+1, with data at N+2.
- Full rises after the edge that accepts the DEPTH-th word. Full falls after the edge that accepts a read.
- Sustained throughput: one write and one read per cycle.

## Configuration
- FIFO_LEVEL_EN defined: the Level port exists, driven as the registered-pointer difference wp − rp (AW+1 bits), with reset value 0.
- FIFO_LEVEL_EN undefined: the Level port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 on consecutive cycles, then Rd for 3 cycles:
  - Q = 0x11, 0x22, 0x33 with QValid high for 3 cycles.
  - Empty = 1 afterwards; Err = 0.
- DEPTH = 4:
  - Write 4 words → Full = 1, Level = 4.
  - 5th write of 0xAA → dropped, Err = 1.
  - Read 4 → the original 4 words come out in order; 0xAA never appears.
- Empty FIFO, Rd = 1 and Wr = 1 (D = 0x5C) in the same cycle:
  - QValid = 0, Err = 1, Level = 1.
  - The next Rd returns 0x5C.
- Wrap-around with DEPTH = 4:
  - 10 cycles of simultaneous Wr/Rd at half occupancy, data 0..9.
  - Output is in order with no loss; pointers pass through the MSB toggle; Full and Empty never assert.
- Assert Rst mid-burst with 3 words stored and Rd = 1 on the reset cycle:
  - Next cycle QValid = 0, Empty = 1, Err = 0, Level = 0.
  - Writes after reset are read back correctly.
- Override check with `#(WIDTH=4, DEPTH=2)`:
  - Full after 2 writes.
  - Q is 4 bits wide and returns 0xF, 0x3 in order.
